gfx_reg_bank: RTL and testbench
===============================

# gfx_reg_bank

Double-buffered register bank that sits directly upstream of the graphics ASIC. It accepts 16-bit CPU writes over the chipselect/data_address/databus interface into shadow registers. On a CPU commit request, it copies all shadow registers into the active registers atomically at the next end-of-frame, so the renderer never draws a half-updated scene. It also provides a frame counter and a per-frame tick the CPU side can poll.

## Interface
Parameters:
- GFX_CS, 4'h2, chipselect value that addresses this block
- LAST_ADDR, 19'h4AFFF, pixel address of the final pixel of a frame
- ZMAX, 16'd999, upper clamp for ball_z writes

Ports:
- clk  in  1  system clock; one clock domain; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- chipselect  in  4  a write occurs in any cycle where chipselect == GFX_CS
- data_address  in  4  register select for the write
- databus  in  16  write data
- VGA_ready  in  1  renderer pixel-advance qualifier
- pixel_address  in  19  current renderer pixel address
- paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y  out  16 each  active paddle positions
- ball_x, ball_y, ball_z  out  16 each  active ball position
- player_1_score, player_2_score, game_state  out  16 each  active values
- commit_pending  out  1  a commit is waiting for end-of-frame
- frame_tick  out  1  one-cycle pulse, first cycle after every end-of-frame
- frame_count  out  16  frames since reset; wraps 16'hFFFF -> 0

## Operation
- Register map (data_address):
  - 0: paddle_1_x
  - 1: paddle_1_y
  - 2: paddle_2_x
  - 3: paddle_2_y
  - 4: ball_x
  - 5: ball_y
  - 6: ball_z
  - 7: player_1_score
  - 8: player_2_score
  - 9: game_state
  - 4'hF: commit (data ignored; sets commit_pending)
  - 10–14: writes are ignored with no side effects.
- The bank is write-only. Writes land in the shadow registers only; the outputs always drive the active registers.
- A ball_z write stores min(databus, ZMAX). All other fields store databus unmodified.
- End-of-frame condition: eof_cond = VGA_ready && pixel_address == LAST_ADDR.
- eof is the rising edge of eof_cond, detected against a registered copy of the previous cycle's eof_cond. If eof_cond is held for several cycles, only one eof is produced.
- On an eof cycle:
  - frame_count increments.
  - frame_tick is set for the next cycle.
  - If commit_pending = 1, all ten shadow registers are copied to the active registers and commit_pending is cleared.
- Commit control is two states: IDLE (commit_pending = 0) and PENDING (commit_pending = 1).
  - IDLE -> PENDING on a commit write.
  - PENDING -> IDLE on eof.
  - A commit write while already PENDING has no additional effect.
- Reset values, identical for shadow and active registers:
  - paddle_1_x = 100, paddle_1_y = 200
  - paddle_2_x = 350, paddle_2_y = 250
  - ball_x = 305, ball_y = 240, ball_z = 0
  - both scores = 0, game_state = 0
- Reset values for control state: commit_pending = 0, frame_tick = 0, frame_count = 0, previous-eof_cond register = 0.

## Timing
- A field write in cycle N is visible in the shadow register from N+1.
- Active outputs change only on the clock edge that ends an eof cycle E. The new values are visible from E+1, and frame_tick is high in E+1 only.
- Field write and eof in the same cycle: the copy uses the shadow value from before the write. The new write stays in shadow and waits for the next commit.
- Commit write and eof in the same cycle: that eof does not copy (commit_pending was 0 at sample time). commit_pending = 1 from the next cycle, and the copy happens at the following eof.
- Commit write and eof in the same cycle while already PENDING: the copy happens and pending clears. The coincident commit write is absorbed by this copy and does not re-arm pending.
- If eof_cond is true in the first cycle after reset, an eof is produced, because the previous-eof_cond register resets to 0.
- Reset asserted mid-frame or while PENDING: all state returns to reset values on that edge, and the pending commit is discarded.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then no writes: outputs show 100/200/350/250/305/240/0/0/0/0; frame_count = 0; commit_pending = 0.
- Write paddle_1_x = 400 and commit, then eof: paddle_1_x stays 100 through the eof cycle, reads 400 at E+1; frame_tick = 1 for exactly one cycle; commit_pending = 0.
- Write ball_x = 500 with no commit, then 3 eofs: ball_x stays 305; frame_count = 3.
- Write ball_z = 1200 and commit, then eof: ball_z = 999. Write ball_z = 10 and commit, then eof: ball_z = 10.
- eof_cond held 5 cycles: exactly one frame_tick; frame_count +1.
- Commit write in the same cycle as eof: no change at that eof; the copy occurs at the next eof. Separately, assert rst while PENDING: commit_pending = 0, outputs at reset values, and the next eof copies nothing.

Source files
------------

// File: rtl/gfx_reg_bank.sv
// gfx_reg_bank: double-buffered register bank for the graphics renderer.
// CPU writes land in shadow registers; a commit request copies every shadow
// register into the active set at the next end-of-frame, so the renderer
// never sees a partially updated scene. Also keeps a frame counter and a
// one-cycle frame tick.
module gfx_reg_bank #(
    parameter logic [3:0]  GFX_CS    = 4'h2,
    parameter logic [18:0] LAST_ADDR = 19'h4AFFF,
    parameter logic [15:0] ZMAX      = 16'd999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  chipselect,
    input  logic [3:0]  data_address,
    input  logic [15:0] databus,
    input  logic        VGA_ready,
    input  logic [18:0] pixel_address,
    output logic [15:0] paddle_1_x,
    output logic [15:0] paddle_1_y,
    output logic [15:0] paddle_2_x,
    output logic [15:0] paddle_2_y,
    output logic [15:0] ball_x,
    output logic [15:0] ball_y,
    output logic [15:0] ball_z,
    output logic [15:0] player_1_score,
    output logic [15:0] player_2_score,
    output logic [15:0] game_state,
    output logic        commit_pending,
    output logic        frame_tick,
    output logic [15:0] frame_count
);

    localparam int         NUM_REGS    = 10;
    localparam logic [3:0] ADDR_BALL_Z = 4'd6;
    localparam logic [3:0] ADDR_COMMIT = 4'hF;

    typedef enum logic {
        IDLE,
        PENDING
    } commit_state_e;

    // Power-on value of each field; shared by shadow and active copies.
    function automatic logic [15:0] reset_value(input int idx);
        case (idx)
            0:       reset_value = 16'd100;
            1:       reset_value = 16'd200;
            2:       reset_value = 16'd350;
            3:       reset_value = 16'd250;
            4:       reset_value = 16'd305;
            5:       reset_value = 16'd240;
            default: reset_value = 16'd0;
        endcase
    endfunction

    logic [15:0]   shadow_q [NUM_REGS];
    logic [15:0]   active_q [NUM_REGS];
    commit_state_e state_q;
    logic          eof_cond_prev_q;
    logic          frame_tick_q;
    logic [15:0]   frame_count_q;

    logic          wr_en;
    logic          field_wr;
    logic          commit_wr;
    logic [15:0]   wr_data;
    logic          eof_cond;
    logic          eof;

    // Decode the CPU write and detect the rising edge of the end-of-frame condition.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        wr_en     = 1'b0;
        field_wr  = 1'b0;
        commit_wr = 1'b0;
        wr_data   = databus;
        eof_cond  = 1'b0;
        eof       = 1'b0;

        wr_en     = (chipselect == GFX_CS);
        field_wr  = wr_en && (data_address < 4'(NUM_REGS));
        commit_wr = wr_en && (data_address == ADDR_COMMIT);
        if (data_address == ADDR_BALL_Z && databus > ZMAX)
            wr_data = ZMAX;
        eof_cond  = VGA_ready && (pixel_address == LAST_ADDR);
        eof       = eof_cond && !eof_cond_prev_q;
    end

    // Shadow registers capture CPU field writes.
    always_ff @(posedge clk) begin
        // NOTE: these register arrays are reset element-by-element because their
        // reset values are architecturally visible; plain storage RAMs would not be.
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                shadow_q[i] <= reset_value(i);
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (field_wr && data_address == 4'(i))
                    shadow_q[i] <= wr_data;
        end
    end

    // Active registers take the whole shadow set at an eof with a commit pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                active_q[i] <= reset_value(i);
        end else if (eof && state_q == PENDING) begin
            // NOTE: non-blocking assignment means this copy sees the shadow values
            // from before any same-cycle write, which is exactly the intended order.
            active_q <= shadow_q;
        end
    end

    // Commit FSM: a commit write arms it, the next eof consumes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (commit_wr) state_q <= PENDING;
                PENDING: if (eof)       state_q <= IDLE;
                default:                state_q <= IDLE;
            endcase
        end
    end

    // Frame bookkeeping: eof edge detector, tick pulse and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            eof_cond_prev_q <= 1'b0;
            frame_tick_q    <= 1'b0;
            frame_count_q   <= 16'd0;
        end else begin
            eof_cond_prev_q <= eof_cond;
            frame_tick_q    <= eof;
            if (eof)
                frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign paddle_1_x     = active_q[0];
    assign paddle_1_y     = active_q[1];
    assign paddle_2_x     = active_q[2];
    assign paddle_2_y     = active_q[3];
    assign ball_x         = active_q[4];
    assign ball_y         = active_q[5];
    assign ball_z         = active_q[6];
    assign player_1_score = active_q[7];
    assign player_2_score = active_q[8];
    assign game_state     = active_q[9];
    assign commit_pending = (state_q == PENDING);
    assign frame_tick     = frame_tick_q;
    assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_gfx_reg_bank.sv
// Testbench for gfx_reg_bank: directed scenarios plus random traffic, each
// cycle's expected post-edge state pushed into a queue by the stimulus and
// compared by an independent monitor one step after the clock edge.
module tb_gfx_reg_bank;

    localparam logic [3:0]  GFX_CS    = 4'h2;
    localparam logic [18:0] LAST_ADDR = 19'h4AFFF;
    localparam logic [15:0] ZMAX      = 16'd999;

    typedef struct packed {
        logic [9:0][15:0] regs;
        logic             pending;
        logic             tick;
        logic [15:0]      fc;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  chipselect;
    logic [3:0]  data_address;
    logic [15:0] databus;
    logic        VGA_ready;
    logic [18:0] pixel_address;
    logic [15:0] dut_regs [10];
    logic        commit_pending;
    logic        frame_tick;
    logic [15:0] frame_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    snap_t exp_q[$];

    // Reference model state: plain arrays and counters.
    logic [15:0] m_shadow [10];
    logic [15:0] m_active [10];
    logic        m_pending;
    logic        m_tick;
    logic        m_prev_cond;
    int          m_fc;

    string names [10] = '{"paddle_1_x", "paddle_1_y", "paddle_2_x", "paddle_2_y",
                          "ball_x", "ball_y", "ball_z", "player_1_score",
                          "player_2_score", "game_state"};
    int reset_vals [10] = '{100, 200, 350, 250, 305, 240, 0, 0, 0, 0};

    always #5 clk = ~clk;

    gfx_reg_bank #(
        .GFX_CS    (GFX_CS),
        .LAST_ADDR (LAST_ADDR),
        .ZMAX      (ZMAX)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .chipselect     (chipselect),
        .data_address   (data_address),
        .databus        (databus),
        .VGA_ready      (VGA_ready),
        .pixel_address  (pixel_address),
        .paddle_1_x     (dut_regs[0]),
        .paddle_1_y     (dut_regs[1]),
        .paddle_2_x     (dut_regs[2]),
        .paddle_2_y     (dut_regs[3]),
        .ball_x         (dut_regs[4]),
        .ball_y         (dut_regs[5]),
        .ball_z         (dut_regs[6]),
        .player_1_score (dut_regs[7]),
        .player_2_score (dut_regs[8]),
        .game_state     (dut_regs[9]),
        .commit_pending (commit_pending),
        .frame_tick     (frame_tick),
        .frame_count    (frame_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus; the model applies the documented rules and the
    // resulting expected state is queued for the monitor.
    task automatic step(input logic r, input logic [3:0] cs, input logic [3:0] a,
                        input logic [15:0] d, input logic vr, input logic [18:0] pa);
        logic  cond, eof, cmt;
        snap_t s;
        @(negedge clk);
        rst = r; chipselect = cs; data_address = a; databus = d;
        VGA_ready = vr; pixel_address = pa;

        cond = vr && (pa == LAST_ADDR);
        if (r) begin
            for (int i = 0; i < 10; i++) begin
                m_shadow[i] = 16'(reset_vals[i]);
                m_active[i] = 16'(reset_vals[i]);
            end
            m_pending = 0; m_tick = 0; m_prev_cond = 0; m_fc = 0;
        end else begin
            eof = cond && !m_prev_cond;
            cmt = (cs == GFX_CS) && (a == 4'hF);
            m_tick = eof;
            if (eof) m_fc = (m_fc + 1) % 65536;
            if (m_pending) begin
                if (eof) begin
                    for (int i = 0; i < 10; i++) m_active[i] = m_shadow[i];
                    m_pending = 0;
                end
            end else if (cmt) begin
                m_pending = 1;
            end
            if (cs == GFX_CS && a < 10)
                m_shadow[a] = (a == 6 && d > ZMAX) ? ZMAX : d;
            m_prev_cond = cond;
        end
        for (int i = 0; i < 10; i++) s.regs[i] = m_active[i];
        s.pending = m_pending;
        s.tick    = m_tick;
        s.fc      = 16'(m_fc);
        exp_q.push_back(s);
    endtask

    task automatic idle();
        step(0, 4'h0, 4'h0, 16'h0, 0, 19'h0);
    endtask

    task automatic eof_cycle();
        step(0, 4'h0, 4'h0, 16'h0, 1, LAST_ADDR);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        step(0, GFX_CS, a, d, 0, 19'h0);
    endtask

    // Monitor: one step after each rising edge, compare DUT outputs against the queued expectation.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (exp_q.size() != 0) begin
            snap_t s;
            s = exp_q.pop_front();
            for (int i = 0; i < 10; i++)
                check(names[i], 32'(dut_regs[i]), 32'(s.regs[i]));
            check("commit_pending", 32'(commit_pending), 32'(s.pending));
            check("frame_tick", 32'(frame_tick), 32'(s.tick));
            check("frame_count", 32'(frame_count), 32'(s.fc));
        end
    end

    initial begin
        int wait_cycles;
        rst = 1; chipselect = 0; data_address = 0; databus = 0;
        VGA_ready = 0; pixel_address = 0;

        // Reset, then quiet cycles.
        step(1, 4'h0, 4'h0, 16'h0, 0, 19'h0);
        step(1, 4'h0, 4'h0, 16'h0, 0, 19'h0);
        repeat (3) idle();

        // Write paddle_1_x and commit, then eof.
        wr(4'd0, 16'd400); wr(4'hF, 16'h1234); idle();
        eof_cycle(); idle(); idle();

        // Uncommitted write survives three eofs without reaching active.
        wr(4'd4, 16'd500);
        repeat (3) begin eof_cycle(); idle(); end

        // ball_z clamping, above and below the limit, plus ZMAX and ZMAX+1 boundaries.
        wr(4'd6, 16'd1200); wr(4'hF, 16'h0); eof_cycle(); idle();
        wr(4'd6, 16'd10);   wr(4'hF, 16'h0); eof_cycle(); idle();
        wr(4'd6, ZMAX + 16'd1); wr(4'hF, 16'h0); eof_cycle(); idle();
        wr(4'd6, ZMAX);     wr(4'hF, 16'h0); eof_cycle(); idle();

        // Ignored addresses and foreign chipselect.
        for (int a = 10; a < 15; a++) wr(4'(a), 16'hBEEF);
        step(0, 4'h3, 4'd1, 16'hDEAD, 0, 19'h0);
        wr(4'hF, 16'h0); eof_cycle(); idle();

        // eof_cond held for five cycles yields one eof.
        repeat (5) eof_cycle();
        idle();

        // Near-misses of the eof condition.
        step(0, 4'h0, 4'h0, 16'h0, 0, LAST_ADDR);
        step(0, 4'h0, 4'h0, 16'h0, 1, LAST_ADDR - 19'd1);
        idle();

        // Commit coincident with eof while idle: copy deferred to the next eof.
        wr(4'd7, 16'd42);
        step(0, GFX_CS, 4'hF, 16'h0, 1, LAST_ADDR);
        idle(); eof_cycle(); idle();

        // Field write coincident with eof while pending: the old shadow value is copied.
        wr(4'd8, 16'd7); wr(4'hF, 16'h0);
        step(0, GFX_CS, 4'd8, 16'd9, 1, LAST_ADDR);
        idle(); wr(4'hF, 16'h0); eof_cycle(); idle();

        // Commit coincident with eof while pending is absorbed.
        wr(4'd9, 16'd3); wr(4'hF, 16'h0);
        step(0, GFX_CS, 4'hF, 16'h0, 1, LAST_ADDR);
        idle(); eof_cycle(); idle();

        // Reset while pending discards the commit; eof right after reset counts.
        wr(4'd2, 16'd77); wr(4'hF, 16'h0);
        step(1, 4'h0, 4'h0, 16'h0, 0, 19'h0);
        eof_cycle(); idle(); eof_cycle(); idle();

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            logic [3:0]  cs;
            logic [18:0] pa;
            cs = ($urandom_range(0, 1) == 1) ? GFX_CS : 4'($urandom);
            pa = ($urandom_range(0, 2) != 0) ? LAST_ADDR : 19'($urandom);
            step(($urandom_range(0, 199) == 0), cs, 4'($urandom),
                 ($urandom_range(0, 3) == 0) ? 16'($urandom_range(990, 1010)) : 16'($urandom),
                 1'($urandom), pa);
        end

        // Drain the scoreboard with a bounded wait.
        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
